cordic_sin_cos: RTL and testbench

CORDIC_SIN_COS -- requirements
Module: cordic_sin_cos

---
 rtl/cordic_sin_cos_if.sv | 24 ++
 rtl/cordic_sin_cos.sv | 142 ++++++++++++++
 tb/tb_cordic_sin_cos.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sin_cos_if.sv
// Request/result bundle for cordic_sin_cos: start pulse and angle in, Q1.8 sine/cosine and done out.
interface cordic_sin_cos_if;
    logic              start;
    logic [8:0]        i_angle;
    logic signed [8:0] sine_out;
    logic signed [8:0] cosine_out;
    logic              done;

    modport master (
        output start,
        output i_angle,
        input  sine_out,
        input  cosine_out,
        input  done
    );

    modport slave (
        input  start,
        input  i_angle,
        output sine_out,
        output cosine_out,
        output done
    );
endinterface

// File: rtl/cordic_sin_cos.sv
// 12-iteration rotation-mode CORDIC producing Q1.8 sine/cosine of a whole-degree angle.
// Define CORDIC_ROUND_EN to round (instead of truncate) on the Q2.14 -> Q1.8 conversion.
module cordic_sin_cos (
    input logic             clk,
    input logic             reset,
    cordic_sin_cos_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic signed [15:0] XInit   = 16'sd9949;
    localparam logic [3:0]         LastIdx = 4'd11;

    state_e            state_q;
    logic signed [15:0] x_q, y_q, z_q;
    logic [3:0]         cnt_q;
    logic               neg_q;
    logic               done_q;
    logic signed [8:0]  sine_q, cosine_q;

    logic [8:0]         ang_wrap;
    logic signed [9:0]  ang_red;
    logic               neg_d;
    logic signed [15:0] z_init;
    logic signed [15:0] x_sh, y_sh, atan_i;
    logic signed [15:0] x_n, y_n, z_n;
    logic signed [8:0]  sine_d, cosine_d;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        unique case (idx)
            4'd0:    atan_lut = 16'sd5760;
            4'd1:    atan_lut = 16'sd3400;
            4'd2:    atan_lut = 16'sd1797;
            4'd3:    atan_lut = 16'sd912;
            4'd4:    atan_lut = 16'sd458;
            4'd5:    atan_lut = 16'sd229;
            4'd6:    atan_lut = 16'sd115;
            4'd7:    atan_lut = 16'sd57;
            4'd8:    atan_lut = 16'sd29;
            4'd9:    atan_lut = 16'sd14;
            4'd10:   atan_lut = 16'sd7;
            4'd11:   atan_lut = 16'sd4;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    // Q2.14 -> Q1.8, then optional negation for the folded half-plane, then clamp.
    function automatic logic signed [8:0] to_q18(input logic signed [15:0] v, input logic n);
        logic signed [16:0] r;
        logic signed [10:0] s;
`ifdef CORDIC_ROUND_EN
        r = {v[15], v} + 17'sd32;
`else
        r = {v[15], v};
`endif
        s = r[16:6];
        if (n) s = -s;
        if (s > 11'sd255)       to_q18 = 9'sd255;
        else if (s < -11'sd256) to_q18 = -9'sd256;
        else                    to_q18 = s[8:0];
    endfunction

    // Fold the captured angle into [-90, 90]; the back half-plane is handled by negation.
    always_comb begin
        ang_wrap = (bus.i_angle >= 9'd360) ? bus.i_angle - 9'd360 : bus.i_angle;
        ang_red  = signed'({1'b0, ang_wrap});
        neg_d    = 1'b0;
        if (ang_wrap >= 9'd91 && ang_wrap <= 9'd270) begin
            ang_red = signed'({1'b0, ang_wrap} - 10'd180);
            neg_d   = 1'b1;
        end else if (ang_wrap >= 9'd271) begin
            ang_red = signed'({1'b0, ang_wrap} - 10'd360);
        end
        z_init = {ang_red[8:0], 7'd0};
    end

    always_comb begin
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_i = atan_lut(cnt_q);
        if (!z_q[15]) begin
            x_n = x_q - y_sh;
            y_n = y_q + x_sh;
            z_n = z_q - atan_i;
        end else begin
            x_n = x_q + y_sh;
            y_n = y_q - x_sh;
            z_n = z_q + atan_i;
        end
        sine_d   = to_q18(y_q, neg_q);
        cosine_d = to_q18(x_q, neg_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            sine_q   <= '0;
            cosine_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        x_q     <= XInit;
                        y_q     <= '0;
                        z_q     <= z_init;
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // cnt_q runs one past the last iteration so the output register
                    // lands on the 13th edge after capture.
                    if (cnt_q > LastIdx) begin
                        sine_q   <= sine_d;
                        cosine_q <= cosine_d;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        x_q   <= x_n;
                        y_q   <= y_n;
                        z_q   <= z_n;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sine_out   = sine_q;
    assign bus.cosine_out = cosine_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_cordic_sin_cos.sv
// Directed self-checking bench for cordic_sin_cos: reset, angle table, latency and control corners.
module tb_cordic_sin_cos;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int checks  = 0;
    int errors  = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_sin_cos_if bus ();

    cordic_sin_cos dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Drive a start pulse; returns just after the capture edge with its cycle stamp.
    task automatic launch(input int a, output int unsigned cap);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.i_angle = 9'(a);
        @(posedge clk);
        #1;
        cap       = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned cap, output int unsigned lat);
        while (bus.done !== 1'b1 && (cyc - cap) < 40) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - cap;
    endtask

    task automatic test_reset();
        bus.start   = 1'b1;
        bus.i_angle = 9'd45;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sine_out !== 9'sd0 || bus.cosine_out !== 9'sd0) begin
            errors++;
            $display("FAIL reset_state: done=%b sine=%0d cos=%0d, want 0 0 0",
                     bus.done, bus.sine_out, bus.cosine_out);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority: done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_angles();
        int ang[8]  = '{0,    90,  180,  359, 45,  270,  400, 360};
        int slo[8]  = '{-1,   255, -2,   -5,  179, -256, 163, -1};
        int shi[8]  = '{1,    255, 2,    -3,  183, -255, 167, 1};
        int clo[8]  = '{255,  -2,  -256, 255, 179, -2,   194, 255};
        int chi[8]  = '{255,  2,   -255, 255, 183, 2,    198, 255};
        int unsigned cap, lat;
        int s, c;
        for (int k = 0; k < 8; k++) begin
            launch(ang[k], cap);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL done_clear angle=%0d: done=%b, want 0", ang[k], bus.done);
            end
            wait_done(cap, lat);
            checks++;
            if (lat != 13) begin
                errors++;
                $display("FAIL latency angle=%0d: got %0d edges, want 13", ang[k], lat);
            end
            s = $signed(bus.sine_out);
            c = $signed(bus.cosine_out);
            checks++;
            if (s < slo[k] || s > shi[k]) begin
                errors++;
                $display("FAIL sine angle=%0d: got %0d, want %0d..%0d", ang[k], s, slo[k], shi[k]);
            end
            checks++;
            if (c < clo[k] || c > chi[k]) begin
                errors++;
                $display("FAIL cosine angle=%0d: got %0d, want %0d..%0d", ang[k], c, clo[k], chi[k]);
            end
        end
    endtask

    task automatic test_restart_in_run();
        int unsigned cap, lat;
        int s, c;
        launch(30, cap);
        repeat (4) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.i_angle = 9'd90;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cap, lat);
        s = $signed(bus.sine_out);
        c = $signed(bus.cosine_out);
        checks++;
        if (lat != 13) begin
            errors++;
            $display("FAIL restart_latency: got %0d edges, want 13", lat);
        end
        checks++;
        if (s < 126 || s > 130 || c < 220 || c > 224) begin
            errors++;
            $display("FAIL restart_result: sine=%0d cos=%0d, want 126..130 220..224", s, c);
        end
    endtask

    task automatic test_hold_and_back_to_back();
        int unsigned cap, lat;
        logic signed [8:0] old_s, old_c;
        int s, c;
        old_s = bus.sine_out;
        old_c = bus.cosine_out;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.sine_out !== old_s || bus.cosine_out !== old_c) begin
            errors++;
            $display("FAIL done_hold: done=%b sine=%0d cos=%0d, want 1 %0d %0d",
                     bus.done, bus.sine_out, bus.cosine_out, old_s, old_c);
        end
        launch(45, cap);
        checks++;
        if (bus.done !== 1'b0 || bus.sine_out !== old_s || bus.cosine_out !== old_c) begin
            errors++;
            $display("FAIL b2b_capture: done=%b sine=%0d cos=%0d, want 0 %0d %0d",
                     bus.done, bus.sine_out, bus.cosine_out, old_s, old_c);
        end
        wait_done(cap, lat);
        s = $signed(bus.sine_out);
        c = $signed(bus.cosine_out);
        checks++;
        if (lat != 13) begin
            errors++;
            $display("FAIL b2b_latency: got %0d edges, want 13", lat);
        end
        checks++;
        if (s < 179 || s > 183 || c < 179 || c > 183) begin
            errors++;
            $display("FAIL b2b_result: sine=%0d cos=%0d, want 179..183 both", s, c);
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned cap;
        bit seen;
        launch(60, cap);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sine_out !== 9'sd0 || bus.cosine_out !== 9'sd0) begin
            errors++;
            $display("FAIL midrun_reset: done=%b sine=%0d cos=%0d, want 0 0 0",
                     bus.done, bus.sine_out, bus.cosine_out);
        end
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_no_done: done asserted after abort, want never");
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.i_angle = 9'd0;
        test_reset();
        test_angles();
        test_restart_in_run();
        test_hold_and_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
